sap_ram: RTL and testbench

- Unified program/data memory of the 16-bit SAP computer. Sits directly downstream of the memory address register and takes its registered 16-bit address as `addr`.
- Performs read or write accesses commanded by the control sequencer, with a configurable wait-state count and a done handshake. Read data returns on a registered output for the bus driver.
- A side loader port preloads program words while the CPU is idle.

---
 rtl/sap_ram_pkg.sv | 20 ++
 rtl/sap_ram_if.sv | 28 ++
 rtl/sap_ram_array.sv | 28 ++
 rtl/sap_ram.sv | 181 ++++++++++++++++++
 tb/tb_sap_ram.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/sap_ram_pkg.sv
// rtl/sap_ram_pkg.sv - shared widths, FSM state type and range helper for sap_ram
package sap_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } ram_state_t;

    typedef logic [3:0] wait_cnt_t;

    // Compared one bit wider so DEPTH=65536 never reports a false overflow.
    function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] a, input int depth);
        return {1'b0, a} >= (ADDR_W + 1)'(depth);
    endfunction

endpackage

// File: rtl/sap_ram_if.sv
// rtl/sap_ram_if.sv - CPU access and loader bus of the SAP unified memory
interface sap_ram_if;
    import sap_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic              ram_read;
    logic              ram_write;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              busy;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ack;
    logic              addr_err;

    modport master (
        output addr, ram_read, ram_write, wdata, ld_we, ld_addr, ld_data,
        input  rdata, done, busy, ld_ack, addr_err
    );

    modport slave (
        input  addr, ram_read, ram_write, wdata, ld_we, ld_addr, ld_data,
        output rdata, done, busy, ld_ack, addr_err
    );

endinterface

// File: rtl/sap_ram_array.sv
// rtl/sap_ram_array.sv - single-port synchronous DEPTH x 16 storage, no reset
module sap_ram_array
    import sap_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    // dout only moves on a read, so it doubles as the held read-data register.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= din;
        end
        if (re) begin
            dout <= mem[idx];
        end
    end

endmodule

// File: rtl/sap_ram.sv
// rtl/sap_ram.sv - SAP unified memory: access FSM with wait states, loader port, range check
// Optional: RAM_ADDR_CHECK_EN enables out-of-range detection instead of address aliasing.
module sap_ram
    import sap_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic     clk,
    input  logic     rst,
    sap_ram_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam wait_cnt_t WAIT_INIT = wait_cnt_t'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    ram_state_t        state_q, state_d;
    wait_cnt_t         cnt_q, cnt_d;
    logic              op_write_q, op_write_d;
    logic [ADDR_W-1:0] addr_lat_q, addr_lat_d;
    logic [DATA_W-1:0] wdata_lat_q, wdata_lat_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ld_ack_q, ld_ack_d;
    logic              addr_err_q, addr_err_d;
    logic              rd_zero_q, rd_zero_d;

    logic              req;
    logic              acc_go;
    logic              acc_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_oor;
    logic              ld_go;
    logic              ld_oor;

    logic              arr_we;
    logic              arr_re;
    logic [IDX_W-1:0]  arr_idx;
    logic [DATA_W-1:0] arr_din;
    logic [DATA_W-1:0] arr_dout;

    assign req = bus.ram_read | bus.ram_write;

    // Sequencing: acc_go marks the cycle whose closing edge is the DONE entry edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_write_d  = op_write_q;
        addr_lat_d  = addr_lat_q;
        wdata_lat_d = wdata_lat_q;
        busy_d      = busy_q;
        acc_go      = 1'b0;
        acc_write   = op_write_q;
        acc_addr    = addr_lat_q;
        acc_wdata   = wdata_lat_q;
        ld_go       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    op_write_d  = bus.ram_write;
                    addr_lat_d  = bus.addr;
                    wdata_lat_d = bus.wdata;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                        busy_d  = 1'b1;
                    end else begin
                        state_d   = DONE;
                        busy_d    = 1'b0;
                        acc_go    = 1'b1;
                        acc_write = bus.ram_write;
                        acc_addr  = bus.addr;
                        acc_wdata = bus.wdata;
                    end
                end else if (bus.ld_we) begin
                    ld_go = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    acc_go  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

`ifdef RAM_ADDR_CHECK_EN
    assign acc_oor = addr_out_of_range(acc_addr, DEPTH);
    assign ld_oor  = addr_out_of_range(bus.ld_addr, DEPTH);
`else
    assign acc_oor = 1'b0;
    assign ld_oor  = 1'b0;
`endif

    // Array port: a CPU access always takes the single port before the loader.
    always_comb begin
        done_d     = 1'b0;
        ld_ack_d   = 1'b0;
        addr_err_d = addr_err_q;
        rd_zero_d  = rd_zero_q;
        arr_we     = 1'b0;
        arr_re     = 1'b0;
        arr_idx    = acc_addr[IDX_W-1:0];
        arr_din    = acc_wdata;
        if (acc_go) begin
            done_d     = 1'b1;
            addr_err_d = acc_oor;
            if (acc_write) begin
                arr_we = ~acc_oor;
            end else begin
                arr_re    = ~acc_oor;
                rd_zero_d = acc_oor;
            end
        end else if (ld_go) begin
            ld_ack_d = 1'b1;
            arr_we   = ~ld_oor;
            arr_idx  = bus.ld_addr[IDX_W-1:0];
            arr_din  = bus.ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_write_q  <= 1'b0;
            addr_lat_q  <= '0;
            wdata_lat_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ld_ack_q    <= 1'b0;
            addr_err_q  <= 1'b0;
            rd_zero_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_write_q  <= op_write_d;
            addr_lat_q  <= addr_lat_d;
            wdata_lat_q <= wdata_lat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ld_ack_q    <= ld_ack_d;
            addr_err_q  <= addr_err_d;
            rd_zero_q   <= rd_zero_d;
        end
    end

    // Array enables are masked by rst so an aborted access can never commit.
    sap_ram_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk  (clk),
        .we   (arr_we & ~rst),
        .re   (arr_re & ~rst),
        .idx  (arr_idx),
        .din  (arr_din),
        .dout (arr_dout)
    );

    logic unused_addr_bits;
    assign unused_addr_bits = ^{acc_addr, bus.ld_addr};

    assign bus.rdata    = rd_zero_q ? '0 : arr_dout;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.ld_ack   = ld_ack_q;
    assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_sap_ram.sv
// tb/tb_sap_ram.sv - randomized and directed self-checking bench for sap_ram
module tb_sap_ram;

    localparam int DEPTH = 256;
    localparam int W     = 1;

    logic clk = 1'b0;
    logic rst;
    sap_ram_if bus();

    sap_ram #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    logic [15:0] mem_m [DEPTH];
    logic [15:0] rdata_m;
    logic        aerr_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic bit m_oor(input int a);
`ifdef RAM_ADDR_CHECK_EN
        return a >= DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    task automatic load(input int a, input logic [15:0] d);
        int n = 0;
        bit got = 0;
        bus.ld_addr = 16'(a);
        bus.ld_data = d;
        bus.ld_we   = 1'b1;
        while (!got && n < 10) begin
            @(posedge clk); #1;
            n++;
            if (bus.ld_ack === 1'b1) got = 1;
        end
        bus.ld_we = 1'b0;
        chk("ld_ack_seen", 32'(got), 32'd1);
        chk("ld_ack_latency", 32'(n), 32'd1);
        if (!m_oor(a)) mem_m[a % DEPTH] = d;
        @(posedge clk); #1;
        chk("ld_ack_pulse", 32'(bus.ld_ack), 32'd0);
    endtask

    task automatic cpu(input bit rd, input bit wr, input int a, input logic [15:0] d);
        int n = 0;
        bit got = 0;
        bus.addr      = 16'(a);
        bus.wdata     = d;
        bus.ram_read  = rd;
        bus.ram_write = wr;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            chk("ld_ack_blocked", 32'(bus.ld_ack), 32'd0);
            if (bus.done === 1'b1) got = 1;
            else begin
                chk("busy_wait", 32'(bus.busy), 32'd1);
                chk("rdata_hold", 32'(bus.rdata), 32'(rdata_m));
            end
        end
        bus.ram_read  = 1'b0;
        bus.ram_write = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        chk("latency", 32'(n), 32'(W + 1));
        aerr_m = m_oor(a);
        if (wr) begin
            if (!m_oor(a)) mem_m[a % DEPTH] = d;
        end else begin
            rdata_m = m_oor(a) ? 16'h0000 : mem_m[a % DEPTH];
        end
        chk("rdata", 32'(bus.rdata), 32'(rdata_m));
        chk("addr_err", 32'(bus.addr_err), 32'(aerr_m));
        chk("busy_done", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        chk("done_pulse", 32'(bus.done), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdata"}, 32'(bus.rdata), 32'h0);
        chk({tag, "_done"}, 32'(bus.done), 32'h0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
        chk({tag, "_ld_ack"}, 32'(bus.ld_ack), 32'h0);
        chk({tag, "_addr_err"}, 32'(bus.addr_err), 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.addr = '0; bus.ram_read = 0; bus.ram_write = 0; bus.wdata = '0;
        bus.ld_we = 0; bus.ld_addr = '0; bus.ld_data = '0;
        rdata_m = 16'h0000;
        aerr_m  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        load(16'h0005, 16'hBEEF);
        cpu(1, 0, 16'h0005, 16'h0000);
        cpu(0, 1, 16'h0010, 16'h1234);
        cpu(1, 0, 16'h0010, 16'h0000);
        cpu(1, 1, 16'h0020, 16'hAAAA);
        cpu(1, 0, 16'h0020, 16'h0000);

        // Loader collides with a CPU read, then retries in the next IDLE cycle.
        bus.ld_addr = 16'h0040; bus.ld_data = 16'hC0DE; bus.ld_we = 1'b1;
        cpu(1, 0, 16'h0005, 16'h0000);
        load(16'h0040, 16'hC0DE);
        cpu(1, 0, 16'h0040, 16'h0000);

        // Reset in the middle of a write's wait state aborts it.
        cpu(0, 1, 16'h0030, 16'h0000);
        bus.addr = 16'h0030; bus.wdata = 16'h7777; bus.ram_write = 1'b1;
        @(posedge clk); #1;
        chk("busy_accept", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("busy_async_rst", 32'(bus.busy), 32'd0);
        bus.ram_write = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_outputs("midrst");
        rdata_m = 16'h0000;
        aerr_m  = 1'b0;
        cpu(1, 0, 16'h0030, 16'h0000);
        cpu(1, 0, 16'h0005, 16'h0000);

        cpu(0, 1, 16'h0105, 16'h5555);
        cpu(1, 0, 16'h0105, 16'h0000);
        cpu(1, 0, 16'h0005, 16'h0000);

        for (int i = 0; i < DEPTH; i++) load(i, 16'($urandom));

        for (int k = 0; k < 40; k++) begin
            int op;
            int a;
            logic [15:0] d;
            op = int'($urandom_range(0, 3));
            a  = int'($urandom_range(0, 2 * DEPTH - 1));
            d  = 16'($urandom);
            case (op)
                0: cpu(1, 0, a, d);
                1: cpu(0, 1, a, d);
                2: cpu(1, 1, a, d);
                default: load(a, d);
            endcase
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
